// File: rtl/lab3_pkg.sv
// Shared types and sizing for the lab3 self-test sweep controller.
package lab3_pkg;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned TABLE_W = NUM_VEC * RESP_W;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/lab3_sweep_ctrl.sv
// Steps lab3 through all eight input vectors, captures {x,y} after a settle
// time, and scores each response against a latched expected table.
module lab3_sweep_ctrl
  import lab3_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TABLE_W-1:0]   exp_table,
  output logic                 dut_a,
  output logic                 dut_b,
  output logic                 dut_c,
  input  logic                 dut_x,
  input  logic                 dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [TABLE_W-1:0]   resp_table,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [IDX_W-1:0]     first_err_idx
);

  sweep_state_t        state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TABLE_W-1:0]  exp_q, exp_d;
  logic [IDX_W-1:0]    vec_d;
  logic                busy_d, done_d, pass_d;
  logic [TABLE_W-1:0]  resp_d;
  logic [ERR_W-1:0]    err_d;
  logic [IDX_W-1:0]    first_d;
  logic [RESP_W-1:0]   resp_now;
  logic [RESP_W-1:0]   exp_now;

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                 <= IDLE;
      idx_q                   <= '0;
      cnt_q                   <= '0;
      exp_q                   <= '0;
      {dut_a, dut_b, dut_c}   <= '0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      pass                    <= 1'b0;
      resp_table              <= '0;
      err_cnt                 <= '0;
      first_err_idx           <= '0;
    end else begin
      state_q                 <= state_d;
      idx_q                   <= idx_d;
      cnt_q                   <= cnt_d;
      exp_q                   <= exp_d;
      {dut_a, dut_b, dut_c}   <= vec_d;
      busy                    <= busy_d;
      done                    <= done_d;
      pass                    <= pass_d;
      resp_table              <= resp_d;
      err_cnt                 <= err_d;
      first_err_idx           <= first_d;
    end
  end

  // Next state, sequencing and scoring.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    vec_d    = {dut_a, dut_b, dut_c};
    busy_d   = busy;
    done_d   = 1'b0;
    pass_d   = pass;
    resp_d   = resp_table;
    err_d    = err_cnt;
    first_d  = first_err_idx;
    resp_now = {dut_x, dut_y};
    exp_now  = exp_q[{idx_q, 1'b0} +: RESP_W];

    case (state_q)
      IDLE: begin
        vec_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d = SETTLE;
          exp_d   = exp_table;
          resp_d  = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      SETTLE: begin
        vec_d = idx_q;
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SAMPLE: begin
        resp_d[{idx_q, 1'b0} +: RESP_W] = resp_now;
        if (resp_now != exp_now) begin
          err_d = err_cnt + ERR_W'(1);
          if (err_cnt == '0) begin
            first_d = idx_q;
          end
        end
        // Explicit exit at the last vector keeps idx from wrapping.
        if (idx_q == IDX_W'(NUM_VEC - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          vec_d   = '0;
          pass_d  = (err_d == '0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + IDX_W'(1);
          vec_d   = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/lab3_sweep_ctrl.md
# lab3_sweep_ctrl

Sequencing controller that drives the three-input combinational `lab3` block through all eight input vectors in hardware. It applies each vector, waits a programmable settle time, and captures the `{x,y}` response. Each response is compared against a caller-supplied expected table, and the controller reports pass/fail, the error count and the first failing vector. It sits beside `lab3` in an on-board self-test wrapper and replaces manual vector stepping with a start/done handshake.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before the sample cycle. Legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: sweep request; honoured only in IDLE.
- `exp_table` input 16: expected responses, bits `[2i+1:2i] = {x,y}` for vector i; latched on start accept.
- `dut_a`, `dut_b`, `dut_c` output 1 each: drive `lab3` inputs, with vector index i = `{a,b,c}` (a is the MSB).
- `dut_x`, `dut_y` input 1 each: `lab3` outputs.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: one-cycle pulse at sweep completion.
- `pass` output 1: `err_cnt==0` for the last completed sweep.
- `resp_table` output 16: captured responses, same packing as `exp_table`.
- `err_cnt` output 4: number of mismatching vectors, 0..8.
- `first_err_idx` output 3: lowest failing vector index; 0 when there is no error.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE:** `dut_a/b/c` are 0 and `busy`=0.
  - `start`=1 moves to SETTLE.
  - On that transition: latch `exp_table`, clear `resp_table`, `err_cnt` and `first_err_idx`, clear `pass`, set idx=0 and settle count=0.
- **SETTLE:** `{dut_a,dut_b,dut_c}` = idx (registered outputs). The settle count increments each cycle; after SETTLE_CYCLES cycles the FSM moves to SAMPLE.
- **SAMPLE (1 cycle, vector still applied):** at the exiting edge:
  - Write `resp_table[2*idx+:2]` = `{dut_x,dut_y}`.
  - On a mismatch with the latched expectation: increment `err_cnt`; if this is the first error, load `first_err_idx`=idx.
  - idx==7 moves to DONE; otherwise idx+1 and back to SETTLE.
- **DONE (1 cycle):** `done`=1, `busy`=0, `pass` updated to `err_cnt==0`, then return to IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE; there is no queuing. A held `start` re-triggers on the first IDLE cycle.
- Results (`pass`, `resp_table`, `err_cnt`, `first_err_idx`) hold until the next accepted start.
- Reset values: state IDLE, `dut_a/b/c`=0, `busy`=0, `done`=0, `pass`=0, `resp_table`=16'h0000, `err_cnt`=0, `first_err_idx`=0.
- Reset mid-sweep: everything returns to its reset value immediately (asynchronous) and the sweep is abandoned with no `done` pulse.
- Width rules:
  - idx is 3 bits and never wraps within a sweep, because the exit at 7 is explicit.
  - `err_cnt` saturates naturally at 8 and needs no overflow logic.

## Timing
- Start accepted at edge E0; vector 0 appears on the `dut_*` outputs after E0.
- With S = SETTLE_CYCLES, vector i is held S+1 cycles and sampled at edge E((i+1)(S+1)).
- `busy` is high from E0 to E(8(S+1)). `done` is high for the cycle after E(8(S+1)), where results are already valid.
- With S=2 the sweep samples at E3, E6, …, E24 and `done` is high between E24 and E25.
- The earliest next start accept is at E26: the start must be seen high in the first IDLE cycle, after E25.
- Outputs are registered; there are no combinational paths from `dut_x/y` to any output.

## Structure
- Shared package `lab3_pkg` holds:
  - the state enum `sweep_state_t`;
  - `NUM_VEC`=8;
  - `RESP_W`=2.
- The controller itself is flat, with no sub-module.
- The natural integration sub-module is `lab3_selftest`, which instantiates `lab3` and `lab3_sweep_ctrl` back to back.

## Test plan
- **Golden sweep:** bench model x=a&b, y=a^b^c, `exp_table`=16'hE114, S=2, pulse `start` → `resp_table`=16'hE114, `err_cnt`=0, `pass`=1, `first_err_idx`=0, `done` high in the cycle after E24.
- **Single mismatch:** same model with `exp_table`=16'hE115 → `err_cnt`=1, `first_err_idx`=0, `pass`=0, `resp_table`=16'hE114.
- **Stuck DUT:** x=y=0 with `exp_table`=16'hE114 → `err_cnt`=5, `first_err_idx`=1, `resp_table`=16'h0000, `pass`=0.
- **Start during busy:** `start` pulse at E5 and E12 of a sweep → ignored; exactly one `done` pulse, with results identical to the golden sweep.
- **Reset mid-sweep:** `rst_n` low at E10 → `busy`, `dut_a/b/c`, `resp_table` and `err_cnt` are 0 immediately with no `done`. A new start then completes with `resp_table`=16'hE114.
- **Minimum settle and back-to-back:** S=1 with `start` held high → first `done` in the cycle after E16, second sweep accepted in the following IDLE cycle, and vector 0 is re-driven.
